// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: states, opcodes,
// ALU/PC select codes and the packed control word.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
  } ctrl_t;

  // Control word common to the four instruction-fetch states.
  function automatic ctrl_t fetch_ctrl(input logic [1:0] byte_idx);
    ctrl_t c;
    c          = '0;
    c.memread  = 1'b1;
    c.irwrite  = 4'b0001 << byte_idx;
    c.alusrcb  = SRCB_ONE;
    c.pcwrite  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mainfsm_outdec.sv
// Moore output decoder: state -> datapath control word (pcen is formed in the top).
// ADDI decode present only when MAINFSM_ADDI_EN is defined.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Decode the current state into enables and mux selects; unlisted fields stay 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH1: ctrl = fetch_ctrl(2'd0);
      S_FETCH2: ctrl = fetch_ctrl(2'd1);
      S_FETCH3: ctrl = fetch_ctrl(2'd2);
      S_FETCH4: ctrl = fetch_ctrl(2'd3);
      S_DECODE: ctrl.alusrcb = SRCB_BOFF;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      S_JEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
`ifdef MAINFSM_ADDI_EN
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWR: ctrl.regwrite = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM: state register, next-state logic and pcen gate.
// Optional ADDI path enabled by defining MAINFSM_ADDI_EN.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic [1:0] pcsource,
  output logic       pcen
);

  state_t state_r;
  state_t next_s;
  ctrl_t  ctrl_s;

  // State register; reset parks the FSM in FETCH1 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH1;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    next_s = S_FETCH1;
    case (state_r)
      S_FETCH1:  next_s = S_FETCH2;
      S_FETCH2:  next_s = S_FETCH3;
      S_FETCH3:  next_s = S_FETCH4;
      S_FETCH4:  next_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB:    next_s = S_MEMADR;
          OP_SB:    next_s = S_MEMADR;
          OP_RTYPE: next_s = S_RTYPEEX;
          OP_BEQ:   next_s = S_BEQEX;
          OP_J:     next_s = S_JEX;
`ifdef MAINFSM_ADDI_EN
          OP_ADDI:  next_s = S_ADDIEX;
`endif
          default:  next_s = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SB) begin
          next_s = S_SBWR;
        end else begin
          next_s = S_LBRD;
        end
      end
      S_LBRD:    next_s = S_LBWR;
      S_RTYPEEX: next_s = S_RTYPEWR;
`ifdef MAINFSM_ADDI_EN
      S_ADDIEX:  next_s = S_ADDIWR;
`endif
      default:   next_s = S_FETCH1;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  assign memread  = ctrl_s.memread;
  assign memwrite = ctrl_s.memwrite;
  assign alusrca  = ctrl_s.alusrca;
  assign alusrcb  = ctrl_s.alusrcb;
  assign aluop    = ctrl_s.aluop;
  assign iord     = ctrl_s.iord;
  assign memtoreg = ctrl_s.memtoreg;
  assign regdst   = ctrl_s.regdst;
  assign regwrite = ctrl_s.regwrite;
  assign irwrite  = ctrl_s.irwrite;
  assign pcsource = ctrl_s.pcsource;
  // Only BEQEX raises pcwritecond, so zero glitches elsewhere cannot load the PC.
  assign pcen     = ctrl_s.pcwrite | (ctrl_s.pcwritecond & zero);

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: random opcode stream against a per-instruction
// step-table reference model, plus reset-mid-instruction checks.
module tb_mainfsm;

  logic       clk, reset, zero;
  logic [5:0] op;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] irwrite;

  int n_checks = 0;
  int n_errors = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .irwrite(irwrite), .pcsource(pcsource), .pcen(pcen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction classes: 0 unknown/NOP, 1 LB, 2 SB, 3 R-type, 4 BEQ, 5 J, 6 ADDI
  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100000: return 1;
      6'b101000: return 2;
      6'b000000: return 3;
      6'b000100: return 4;
      6'b000010: return 5;
`ifdef MAINFSM_ADDI_EN
      6'b001000: return 6;
`endif
      default:   return 0;
    endcase
  endfunction

  function automatic int instr_len(input logic [5:0] o);
    int extra[7] = '{0, 3, 2, 2, 1, 1, 2};
    return 5 + extra[classify(o)];
  endfunction

  // Expected control word for step s of an instruction:
  // {memread,memwrite,alusrca,alusrcb,aluop,iord,memtoreg,regdst,regwrite,irwrite,pcsource,pcen}
  function automatic logic [17:0] exp_word(input logic [5:0] o, input int s, input logic z);
    logic mr = 0, mw = 0, asa = 0, iod = 0, m2r = 0, rd = 0, rw = 0, pc = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    logic [3:0] irw = 0;
    int k = s - 5;
    int c = classify(o);
    if (s < 4) begin
      mr = 1; irw = 4'(1 << s); asb = 2'd1; pc = 1;
    end else if (s == 4) begin
      asb = 2'd3;
    end else begin
      case (c)
        1: if (k == 0) begin asa = 1; asb = 2'd2; end
           else if (k == 1) begin mr = 1; iod = 1; end
           else begin rw = 1; m2r = 1; end
        2: if (k == 0) begin asa = 1; asb = 2'd2; end
           else begin mw = 1; iod = 1; end
        3: if (k == 0) begin asa = 1; aop = 2'd2; end
           else begin rw = 1; rd = 1; end
        4: begin asa = 1; aop = 2'd1; pcs = 2'd1; pc = z; end
        5: begin pc = 1; pcs = 2'd2; end
        6: if (k == 0) begin asa = 1; asb = 2'd2; end
           else rw = 1;
        default: ;
      endcase
    end
    return {mr, mw, asa, asb, aop, iod, m2r, rd, rw, irw, pcs, pc};
  endfunction

  function automatic logic [17:0] dut_word();
    return {memread, memwrite, alusrca, alusrcb, aluop, iord, memtoreg, regdst,
            regwrite, irwrite, pcsource, pcen};
  endfunction

  // Runs one instruction starting mid-cycle in FETCH1; abort_at >= 0 fires reset in that step.
  task automatic run_instr(input logic [5:0] o, input int abort_at);
    int len = instr_len(o);
    op = o;
    for (int s = 0; s < len; s++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("op%06b_step%0d", o, s), 32'(dut_word()), 32'(exp_word(o, s, zero)));
      check("mr_mw_excl", 32'(memread & memwrite), 32'd0);
      check("rw_mw_excl", 32'(regwrite & memwrite), 32'd0);
      if (s == abort_at) begin
        #1 reset = 1'b1;
        #1 check("reset_async", 32'(dut_word()), 32'(exp_word(o, 0, zero)));
        @(posedge clk); #1;
        check("reset_hold", 32'(dut_word()), 32'(exp_word(o, 0, zero)));
        #1 reset = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
  endtask

  logic [5:0] ops[8] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100,
                         6'b000010, 6'b001000, 6'b111111, 6'b000000};

  initial begin
    reset = 1'b1; op = 6'd0; zero = 1'b1;
    #3 check("reset_state", 32'(dut_word()), 32'(exp_word(6'd0, 0, 1'b1)));
    @(posedge clk); #2;
    reset = 1'b0;
    // directed: R-type, LB, SB, BEQ both zero values, unknown, 001000
    run_instr(6'b000000, -1);
    run_instr(6'b100000, -1);
    run_instr(6'b101000, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b001000, -1);
    // reset in LBRD (step 6) abandons LB; next instruction must start at FETCH1
    run_instr(6'b100000, 6);
    run_instr(6'b000000, -1);
    for (int i = 0; i < 60; i++) begin
      logic [5:0] o;
      if ($urandom_range(0, 3) == 0) o = 6'($urandom());
      else o = ops[$urandom_range(0, 7)];
      run_instr(o, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
